// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with a single-cycle expiry pulse.
// Define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN to reload from the preset on expiry (periodic divider).
module down_counter_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear_b,
    input  logic             enable_signal,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] start_value;

    // A start coinciding with a load begins from the freshly loaded value.
    assign start_value = load ? load_value : q;
    assign busy        = (state == RUN);

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clock) begin
        if (!clear_b) begin
            reload_reg <= '0;
        end else if (state == IDLE && load) begin
            reload_reg <= load_value;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!clear_b) begin
            q     <= '0;
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        q <= load_value;
                    end
                    if (start) begin
                        if (start_value != '0) begin
                            state <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (enable_signal) begin
                        if (q > WIDTH'(1)) begin
                            q <= q - WIDTH'(1);
                        end else begin
                            done <= 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                            q <= reload_reg;
                            if (reload_reg == '0) begin
                                state <= IDLE;
                            end
`else
                            q     <= '0;
                            state <= IDLE;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (one-shot build; auto-reload checks under its macro).
module tb_down_counter_timer;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             clear_b;
    logic             enable_signal;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clock         (clock),
        .clear_b       (clear_b),
        .enable_signal (enable_signal),
        .load          (load),
        .load_value    (load_value),
        .start         (start),
        .stop          (stop),
        .q             (q),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs may be changed and outputs sampled after return.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk3(input string tag, input int eq, input bit eb, input bit ed);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        clear_b = 1'b0; enable_signal = 1'b0; load = 1'b0;
        load_value = '0; start = 1'b0; stop = 1'b0;
        tick();
        chk3("reset", 0, 0, 0);
        clear_b = 1'b1;

        // Preset 5, start, count to expiry
        load = 1'b1; load_value = 8'd5;
        tick();
        chk3("load5", 5, 0, 0);
        load = 1'b0; start = 1'b1; enable_signal = 1'b1;
        tick();
        chk3("start5", 5, 1, 0);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk3($sformatf("cnt5_%0d", k), 5 - k, k < 5, k == 5);
        end
        tick();
        chk3("post5", 0, 0, 0);

        // Load and start on the same edge
        load = 1'b1; start = 1'b1; load_value = 8'd3;
        tick();
        chk3("ldst3", 3, 1, 0);
        load = 1'b0; start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk3($sformatf("cnt3_%0d", k), 3 - k, k < 3, k == 3);
        end

        // Pause, stop, resume
        load = 1'b1; start = 1'b1; load_value = 8'd6;
        tick();
        chk3("ldst6", 6, 1, 0);
        load = 1'b0; start = 1'b0;
        tick(); tick();
        chk3("at4", 4, 1, 0);
        enable_signal = 1'b0;
        tick();
        chk3("hold1", 4, 1, 0);
        tick();
        chk3("hold2", 4, 1, 0);
        stop = 1'b1;
        tick();
        chk3("stop4", 4, 0, 0);
        stop = 1'b0; start = 1'b1; enable_signal = 1'b1;
        tick();
        chk3("resume4", 4, 1, 0);
        start = 1'b0;
        tick(); tick(); tick();
        chk3("at1", 1, 1, 0);

        // Stop beats the terminal step
        stop = 1'b1;
        tick();
        chk3("stop1", 1, 0, 0);
        stop = 1'b0; start = 1'b1;
        tick();
        chk3("restart1", 1, 1, 0);
        start = 1'b0;

        // Load on the expiry edge is ignored
        load = 1'b1; load_value = 8'd9;
        tick();
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        chk3("expire_ld", 6, 1, 1);
        load = 1'b0; stop = 1'b1;
        tick();
        chk3("stop_ar", 6, 0, 0);
        stop = 1'b0;
`else
        chk3("expire_ld", 0, 0, 1);
        load = 1'b0;
`endif

        // Reset mid-run, then zero-value start
        load = 1'b1; start = 1'b1; load_value = 8'h37; enable_signal = 1'b0;
        tick();
        chk3("ld37", 8'h37, 1, 0);
        load = 1'b0; start = 1'b0; clear_b = 1'b0;
        tick();
        chk3("midreset", 0, 0, 0);
        clear_b = 1'b1; start = 1'b1;
        tick();
        chk3("zerostart", 0, 0, 1);
        start = 1'b0;
        tick();
        chk3("zeropost", 0, 0, 0);

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        // Periodic reload with period 3
        load = 1'b1; start = 1'b1; load_value = 8'd3; enable_signal = 1'b1;
        tick();
        chk3("ar_start", 3, 1, 0);
        load = 1'b0; start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk3($sformatf("ar_%0d", k), 3 - (k % 3), 1, (k % 3) == 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
